// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM port-0 controller state type.
// Ports: none (package). Provides HTRANS/HSIZE/HRESP encodings, the
// controller state enum and a helper that flags active transfer types.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR    = 2'b01,
    ST_RWAIT = 2'b10
  } ctrl_state_e;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
  function automatic logic ahb_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_byte_mask.sv
// Byte-lane write mask for a 32-bit AHB-Lite slave, from HSIZE and HADDR[1:0].
// Ports: hsize (transfer size), haddr_lo (byte offset) -> mask (4 lanes).
// Purely combinational; misaligned transfers are not checked.
module ahbl_byte_mask
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  output logic [3:0] mask
);

  always_comb begin
    mask = 4'b1111;
    if (hsize == HSIZE_BYTE) begin
      mask = 4'b0001 << haddr_lo;
    end else if (hsize == HSIZE_HALF) begin
      mask = haddr_lo[1] ? 4'b1100 : 4'b0011;
    end
  end

endmodule

// File: rtl/ahbl_sram_port0_ctrl.sv
// AHB-Lite slave driving port 0 (RW) of a 32x512 single-clock OpenRAM macro.
// Ports: AHB-Lite slave (HCLK/HRESET, HSEL..HWDATA in, HRDATA/HREADYOUT/HRESP
// out) and SRAM port 0 (csb0/web0/wmask0/addr0/din0 out, dout0 in).
module ahbl_sram_port0_ctrl
  import ahbl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_WMASKS-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  valid;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            bus_mask;
  logic                  unused_haddr_hi;

  assign valid           = HSEL & HREADY & ahb_active(HTRANS);
  assign haddr_word      = HADDR[ADDR_WIDTH+1:2];
  assign unused_haddr_hi = ^HADDR[31:ADDR_WIDTH+2];

  // The SRAM output register already gives data in the data phase, so read
  // data is a straight pass-through.
  assign HRDATA = sram_dout0;
  assign HRESP  = HRESP_OKAY;

  ahbl_byte_mask u_byte_mask (
    .hsize    (HSIZE),
    .haddr_lo (HADDR[1:0]),
    .mask     (bus_mask)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    din_d       = din_q;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = addr_q;
    sram_din0   = din_q;
    HREADYOUT   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (HWRITE) begin
            // Write data is not on the bus yet; strobe in the data phase.
            addr_d  = haddr_word;
            mask_d  = bus_mask;
            state_d = ST_WR;
          end else begin
            // Read goes straight to the SRAM from the address phase.
            sram_csb0  = 1'b0;
            sram_addr0 = haddr_word;
          end
        end
      end

      ST_WR: begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = mask_q;
        sram_din0   = HWDATA;
        din_d       = HWDATA;
        if (valid) begin
          addr_d = haddr_word;
          if (HWRITE) begin
            mask_d = bus_mask;
          end else begin
            // Port is busy writing this cycle; the read takes the next one.
            state_d = ST_RWAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RWAIT: begin
        sram_csb0 = 1'b0;
        HREADYOUT = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While reset is held, nothing may reach the macro, including a read
    // address phase decoded combinationally from the bus.
    if (HRESET) begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = addr_q;
      sram_din0   = din_q;
      HREADYOUT   = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_port0_ctrl.sv
// Bench for ahbl_sram_port0_ctrl: pipelined AHB-Lite master, behavioural
// SRAM macro and a word-array reference model of memory contents and timing.
module tb_ahbl_sram_port0_ctrl;
  import ahbl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic        ext_stall;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT & ~ext_stall;

  ahbl_sram_port0_ctrl dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HWRITE      (HWRITE),
    .HREADY      (HREADY),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Behavioural macro: registers inputs on posedge, read data appears after it.
  typedef struct packed {
    logic [8:0]  a;
    logic [3:0]  m;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem [512];
  logic [31:0] mw;
  wr_t         wlog[$];

  always @(posedge HCLK) begin
    if (sram_csb0 === 1'b0) begin
      if (sram_web0 === 1'b0) begin
        mw = mem[sram_addr0];
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mw[8*b +: 8] = sram_din0[8*b +: 8];
        mem[sram_addr0] <= mw;
        wlog.push_back({sram_addr0, sram_wmask0, sram_din0});
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  // Reference model: memory as an array of words, transfers as a list.
  typedef struct {
    int          kind;   // 0 read, 1 write, 2 idle slot
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic [31:0] ref_mem [512];
  xfer_t       q[$];
  wr_t         wexp[$];
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input int k, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.kind = k; x.addr = a; x.size = s; x.wdata = d;
    q.push_back(x);
  endtask

  // Drives the queued transfers back to back, pipelined, then checks read
  // data, total wait states and every write strobe seen by the macro.
  task automatic run_q(input string tag);
    int n, ap, dp, waits, exp_waits, cyc, lane0, nl, wi;
    logic rdy;
    logic [31:0] w;
    n = q.size(); ap = 0; dp = -1; waits = 0; cyc = 0; exp_waits = 0;
    for (int i = 1; i < n; i++)
      if (q[i].kind == 0 && q[i-1].kind == 1) exp_waits++;
    while ((ap < n || dp >= 0) && cyc < 4*n + 20) begin
      cyc++;
      if (ap < n && q[ap].kind != 2) begin
        HSEL   = 1'b1;
        HTRANS = (ap % 2 == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        HADDR  = q[ap].addr;
        HWRITE = (q[ap].kind == 1);
        HSIZE  = q[ap].size;
      end else begin
        HSEL   = (ap % 3 != 0);
        HTRANS = HSEL ? ((ap % 2 == 1) ? HTRANS_BUSY : HTRANS_IDLE) : HTRANS_NONSEQ;
        HADDR  = $urandom;
        HWRITE = 1'b1;
        HSIZE  = HSIZE_WORD;
      end
      HWDATA = (dp >= 0 && q[dp].kind == 1) ? q[dp].wdata : $urandom;
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (!rdy) waits++;
      if (rdy && dp >= 0 && q[dp].kind == 0) begin
        chk({tag, " rdata"}, HRDATA, ref_mem[q[dp].addr[10:2]]);
        last_rdata = HRDATA;
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        if (dp >= 0 && q[dp].kind == 1) begin
          nl    = (q[dp].size == HSIZE_BYTE) ? 1 : (q[dp].size == HSIZE_HALF) ? 2 : 4;
          lane0 = (nl == 1) ? int'(q[dp].addr % 4) : (nl == 2) ? int'((q[dp].addr % 4) / 2 * 2) : 0;
          w = ref_mem[q[dp].addr[10:2]];
          for (int l = lane0; l < lane0 + nl; l++) w[8*l +: 8] = q[dp].wdata[8*l +: 8];
          ref_mem[q[dp].addr[10:2]] = w;
          wexp.push_back({q[dp].addr[10:2], 4'(((1 << nl) - 1) << lane0), q[dp].wdata});
        end
        if (ap < n) begin dp = ap; ap++; end
        else dp = -1;
      end
    end
    chk({tag, " completed"}, 64'(ap == n && dp < 0), 64'd1);
    chk({tag, " wait states"}, 64'(waits), 64'(exp_waits));
    chk({tag, " strobe count"}, 64'(wlog.size()), 64'(wexp.size()));
    wi = (wlog.size() < wexp.size()) ? wlog.size() : wexp.size();
    for (int i = 0; i < wi; i++) chk({tag, " strobe"}, 64'(wlog[i]), 64'(wexp[i]));
    q.delete(); wlog.delete(); wexp.delete();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  initial begin
    int k, sz;
    logic [31:0] a;
    HRESET = 1'b1; ext_stall = 1'b0;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 32'h8;
    HSIZE = HSIZE_WORD; HWDATA = '0; last_rdata = '0;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'hA000_0000 + i * 32'h0003_0007;
      ref_mem[i] = 32'hA000_0000 + i * 32'h0003_0007;
    end
    @(negedge HCLK);
    chk("reset csb0 with read on bus", 64'(sram_csb0), 64'd1);
    chk("reset hreadyout", 64'(HREADYOUT), 64'd1);
    repeat (2) @(posedge HCLK);
    #1; HRESET = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE;

    // Idle bus after reset: no macro activity.
    for (int c = 0; c < 10; c++) begin
      @(negedge HCLK);
      chk("idle csb0", 64'(sram_csb0), 64'd1);
      chk("idle web0", 64'(sram_web0), 64'd1);
      chk("idle wmask0", 64'(sram_wmask0), 64'd0);
      chk("idle hreadyout", 64'(HREADYOUT), 64'd1);
      chk("idle hresp", 64'(HRESP), 64'd0);
      @(posedge HCLK); #1;
    end
    chk("idle addr0", 64'(sram_addr0), 64'd0);
    chk("idle din0", 64'(sram_din0), 64'd0);

    // Word write then read of the same word.
    add(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    add(0, 32'h10, HSIZE_WORD, 32'h0);
    run_q("raw word");
    chk("raw word value", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

    // Byte write into lane 2 over a known word.
    add(1, 32'h10, HSIZE_WORD, 32'h11223344);
    add(1, 32'h12, HSIZE_BYTE, 32'h55AA5555);
    add(2, 32'h0, HSIZE_WORD, 32'h0);
    add(0, 32'h10, HSIZE_WORD, 32'h0);
    run_q("byte lane");
    chk("byte lane value", 64'(last_rdata), 64'h0000_0000_11AA_3344);

    // Half write then a burst of writes, then read everything back.
    add(1, 32'h16, HSIZE_HALF, 32'hBEEF1234);
    for (int i = 0; i < 4; i++) add(1, 32'h18 + 4*i, HSIZE_WORD, $urandom);
    for (int i = 0; i < 5; i++) add(0, 32'h14 + 4*i, HSIZE_WORD, 32'h0);
    run_q("half burst");

    // Back-to-back reads of untouched preload data.
    add(0, 32'h0, HSIZE_WORD, 32'h0);
    add(0, 32'h4, HSIZE_WORD, 32'h0);
    add(0, 32'h8, HSIZE_WORD, 32'h0);
    run_q("read burst");
    chk("read burst last", 64'(last_rdata), 64'(32'hA000_0000 + 2 * 32'h0003_0007));

    // Reset in the middle of a write data phase.
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("wr phase strobe", 64'(sram_csb0), 64'd0);
    #2 HRESET = 1'b1;
    #1;
    chk("reset in wr csb0", 64'(sram_csb0), 64'd1);
    chk("reset in wr web0", 64'(sram_web0), 64'd1);
    chk("reset in wr wmask0", 64'(sram_wmask0), 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    chk("reset addr0", 64'(sram_addr0), 64'd0);
    add(0, 32'h40, HSIZE_WORD, 32'h0);
    run_q("after reset");

    // Another slave holds HREADY low: address phase must be ignored.
    ext_stall = 1'b1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 32'h4;
    @(negedge HCLK);
    chk("stalled read csb0", 64'(sram_csb0), 64'd1);
    @(posedge HCLK); #1;
    HWRITE = 1'b1;
    @(posedge HCLK); #1;
    ext_stall = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    chk("stalled write csb0", 64'(sram_csb0), 64'd1);
    chk("stalled write count", 64'(wlog.size()), 64'd0);
    @(posedge HCLK); #1;

    // Randomized mixes of reads, writes and idle slots.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 25; i++) begin
        k = $urandom_range(9);
        a = 32'($urandom_range(31)) * 4;
        if (k <= 3) begin
          add(0, a, HSIZE_WORD, 32'h0);
        end else if (k <= 8) begin
          sz = $urandom_range(2);
          if (sz == 0) a = a + 32'($urandom_range(3));
          else if (sz == 1) a = a + 32'($urandom_range(1)) * 2;
          add(1, a, 3'(sz), $urandom);
        end else begin
          add(2, 32'h0, HSIZE_WORD, 32'h0);
        end
      end
      run_q("random");
    end

    // Final sweep: macro contents against the reference.
    for (int i = 0; i < 32; i++) add(0, 32'(i) * 4, HSIZE_WORD, 32'h0);
    run_q("sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
